uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive front end: oversamples RX_IN, majority-votes each bit, and runs the frame FSM through start, data, optional parity and stop.
- Deserializes data LSB-first onto P_DATA.
- Drives the downstream parity checker with sampled_bit and a one-cycle par_chk_en, and consumes its registered par_err.
- Reports one-cycle data_valid / par_err_o / stp_err / strt_glitch status pulses to the RX output register stage.

Parameters:
data_wd, 8, data bits per frame (P_DATA width)
ps_wd, 6, width of PRESCALE and the internal edge counter

Ports:
CLK  in  1  single clock; all logic on rising edge
RST  in  1  reset; synchronous, active-high
RX_IN  in  1  serial line, idle high; already synchronized to CLK
PRESCALE  in  ps_wd  oversampling ratio (clocks per bit); legal values 8, 16, 32
PAR_EN  in  1  1 = frame carries a parity bit
par_err  in  1  registered result from the parity checker; valid the cycle after par_chk_en
P_DATA  out  data_wd  deserialized byte; stable from the end of the last data bit until the next frame's first data bit
sampled_bit  out  1  majority-voted value of the current bit
par_chk_en  out  1  one-cycle enable to the parity checker
data_valid  out  1  one-cycle pulse: frame good, P_DATA valid
par_err_o  out  1  one-cycle pulse: parity error
stp_err  out  1  one-cycle pulse: stop bit sampled 0
strt_glitch  out  1  one-cycle pulse: start bit rejected

Behaviour:
- Reset: the synchronous RST=1 forces the following on the next edge, regardless of state (including mid-frame), and holds them while asserted:
  - FSM to IDLE; edge_cnt=0, bit_cnt=0.
  - P_DATA=0, sampled_bit=0, par_chk_en=0, data_valid=0, par_err_o=0, stp_err=0, strt_glitch=0.
- Configuration latch: PRESCALE and PAR_EN are captured in the IDLE->START cycle. Changes mid-frame are ignored.
- Edge counter:
  - Counts 0..P-1 within each bit (P = latched PRESCALE), then wraps to 0 while the FSM advances to the next bit.
  - The IDLE cycle that sees RX_IN=0 is edge 0 of the start bit.
- Sampling:
  - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1.
  - sampled_bit is updated at edge P/2+2 with the 2-of-3 majority and held until the next update.
- FSM states and transitions:
  - IDLE: RX_IN=0 -> START (edge_cnt=1 next).
  - START: at edge P/2+2, if the voted bit is 1 -> IDLE and pulse strt_glitch. Otherwise, at edge P-1 -> DATA.
  - DATA:
    - At edge P/2+2, shift the voted bit into P_DATA[bit_cnt] (LSB first).
    - At edge P-1, bit_cnt increments.
    - After bit_cnt reaches data_wd-1 and edge P-1 is reached, go to PARITY if PAR_EN, else STOP; bit_cnt clears.
  - PARITY:
    - par_chk_en is asserted for exactly one cycle, the cycle after sampled_bit updates (edge P/2+3).
    - par_err is taken at edge P/2+4 into an internal flag.
    - At edge P-1 -> STOP.
  - STOP: at edge P-1 -> IDLE, and exactly one of the following pulses is registered for the next cycle:
    - voted stop = 0 -> stp_err.
    - else PAR_EN and parity flag set -> par_err_o.
    - else -> data_valid.
- Status pulses are never asserted together and always last exactly one cycle.
- Back-to-back frames: RX_IN=0 during the pulse cycle (now in IDLE) starts the next frame with no lost cycle.
- The parity flag and bit_cnt clear on every IDLE->START transition.
- Glitch on the line inside a data bit outside the three sample edges has no effect. A single disagreeing sample is outvoted.

Test Plan:
- PRESCALE=8, PAR_EN=0, frame 0x A5 (start, 10100101 LSB-first, stop) -> exactly one data_valid pulse, P_DATA=0xA5, no error pulses, FSM in IDLE 80 clocks after the start edge.
- PRESCALE=16, PAR_EN=1, 0x3C with correct even parity (bit 0), par_err held 0 -> par_chk_en pulses once at edge 11 of the parity bit; data_valid=1, P_DATA=0x3C.
- PRESCALE=32, PAR_EN=1, 0x81, par_err driven 1 after par_chk_en -> par_err_o pulse, no data_valid.
- PRESCALE=8, frame 0x55 with stop bit forced 0 -> stp_err pulse only. A following frame 0x0F sent back-to-back -> data_valid, P_DATA=0x0F.
- Start glitch: RX_IN low for 3 clocks at PRESCALE=16 -> strt_glitch pulse, FSM returns to IDLE, no P_DATA change. A single-sample spike at edge P/2 inside a data bit -> byte still correct.
- RST=1 mid DATA bit 4 of frame 0xFF -> next cycle all outputs 0, IDLE. A clean 0x12 frame afterwards -> data_valid, P_DATA=0x12.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receive controller, the parity checker and the RX output register stage.
interface uart_rx_ctrl_if #(
  parameter int data_wd = 8
);
  logic [data_wd-1:0] P_DATA;
  logic               sampled_bit;
  logic               par_chk_en;
  logic               par_err;
  logic               data_valid;
  logic               par_err_o;
  logic               stp_err;
  logic               strt_glitch;

  modport master (
    output P_DATA, sampled_bit, par_chk_en, data_valid, par_err_o, stp_err, strt_glitch,
    input  par_err
  );

  modport slave (
    input  P_DATA, sampled_bit, par_chk_en, data_valid, par_err_o, stp_err, strt_glitch,
    output par_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: oversampled 2-of-3 bit voting, LSB-first deserialization,
// start/data/parity/stop frame sequencing and one-cycle status pulses.
module uart_rx_ctrl #(
  parameter int data_wd = 8,
  parameter int ps_wd   = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [ps_wd-1:0] PRESCALE,
  input  logic             PAR_EN,
  uart_rx_ctrl_if.master   bus
);
  localparam int bc_wd = (data_wd > 1) ? $clog2(data_wd) : 1;
  localparam logic [ps_wd-1:0] one      = ps_wd'(1);
  localparam logic [ps_wd-1:0] two      = ps_wd'(2);
  localparam logic [bc_wd-1:0] bit_last = bc_wd'(data_wd - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [ps_wd-1:0] edge_cnt;
  logic [bc_wd-1:0] bit_cnt;
  logic [ps_wd-1:0] psc_l;
  logic             par_en_l;
  logic             par_flag;
  logic             par_pend;
  logic [2:0]       smp;

  logic [ps_wd-1:0] half, e_s0, e_s2, e_upd, e_last;
  logic             vote;

  // Sample and decision edges derived from the prescale latched for this frame.
  always_comb begin
    half   = psc_l >> 1;
    e_s0   = half - one;
    e_s2   = half + one;
    e_upd  = half + two;
    e_last = psc_l - one;
    vote   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      edge_cnt        <= '0;
      bit_cnt         <= '0;
      psc_l           <= ps_wd'(8);
      par_en_l        <= 1'b0;
      par_flag        <= 1'b0;
      par_pend        <= 1'b0;
      smp             <= '0;
      bus.P_DATA      <= '0;
      bus.sampled_bit <= 1'b0;
      bus.par_chk_en  <= 1'b0;
      bus.data_valid  <= 1'b0;
      bus.par_err_o   <= 1'b0;
      bus.stp_err     <= 1'b0;
      bus.strt_glitch <= 1'b0;
    end else begin
      bus.par_chk_en  <= 1'b0;
      bus.data_valid  <= 1'b0;
      bus.par_err_o   <= 1'b0;
      bus.stp_err     <= 1'b0;
      bus.strt_glitch <= 1'b0;

      // The checker answers one cycle after its enable; grab the result then.
      par_pend <= bus.par_chk_en;
      if (par_pend)
        par_flag <= bus.par_err;

      if (state != IDLE) begin
        edge_cnt <= (edge_cnt == e_last) ? '0 : edge_cnt + one;
        if (edge_cnt == e_s0) smp[0] <= RX_IN;
        if (edge_cnt == half) smp[1] <= RX_IN;
        if (edge_cnt == e_s2) smp[2] <= RX_IN;
        if (edge_cnt == e_upd) bus.sampled_bit <= vote;
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state    <= START;
            edge_cnt <= one;
            psc_l    <= PRESCALE;
            par_en_l <= PAR_EN;
            par_flag <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (edge_cnt == e_upd && vote) begin
            state           <= IDLE;
            edge_cnt        <= '0;
            bus.strt_glitch <= 1'b1;
          end else if (edge_cnt == e_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (edge_cnt == e_upd)
            bus.P_DATA[bit_cnt] <= vote;
          if (edge_cnt == e_last) begin
            if (bit_cnt == bit_last) begin
              bit_cnt <= '0;
              state   <= par_en_l ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (edge_cnt == e_upd)
            bus.par_chk_en <= 1'b1;
          if (edge_cnt == e_last)
            state <= STOP;
        end
        STOP: begin
          if (edge_cnt == e_last) begin
            state <= IDLE;
            if (!bus.sampled_bit)
              bus.stp_err <= 1'b1;
            else if (par_en_l && par_flag)
              bus.par_err_o <= 1'b1;
            else
              bus.data_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with a registered parity-checker model.
module tb_uart_rx_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       inj_par_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, sg_cnt = 0, chk_cnt = 0, ovl_cnt = 0;
  int dv_cyc = 0, pe_cyc = 0, sg_cyc = 0, chk_cyc = 0;

  uart_rx_ctrl_if #(.data_wd(8)) bus ();

  uart_rx_ctrl #(.data_wd(8), .ps_wd(6)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .PRESCALE (PRESCALE),
    .PAR_EN   (PAR_EN),
    .bus      (bus.master)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Parity checker stand-in: answers one cycle after its enable.
  always @(posedge CLK) begin
    if (RST) bus.par_err <= 1'b0;
    else     bus.par_err <= bus.par_chk_en ? inj_par_err : 1'b0;
  end

  always @(negedge CLK) begin
    if (bus.data_valid === 1'b1)  begin dv_cnt++;  dv_cyc  = cyc; end
    if (bus.par_err_o === 1'b1)   begin pe_cnt++;  pe_cyc  = cyc; end
    if (bus.stp_err === 1'b1)     se_cnt++;
    if (bus.strt_glitch === 1'b1) begin sg_cnt++;  sg_cyc  = cyc; end
    if (bus.par_chk_en === 1'b1)  begin chk_cnt++; chk_cyc = cyc; end
    if ($countones({bus.data_valid === 1'b1, bus.par_err_o === 1'b1,
                    bus.stp_err === 1'b1, bus.strt_glitch === 1'b1}) > 1)
      ovl_cnt++;
  end

  task automatic send_frame(input logic [7:0] data, input int p, input bit par_en,
                            input bit par_bit, input bit stop_bit, input int spike_bit,
                            output int c0);
    int   nb;
    logic v;
    PRESCALE = 6'(p);
    PAR_EN   = par_en;
    nb = par_en ? 11 : 10;
    c0 = cyc;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                 v = 1'b0;
      else if (b <= 8)            v = data[b-1];
      else if (par_en && b == 9)  v = par_bit;
      else                        v = stop_bit;
      for (int k = 0; k < p; k++) begin
        RX_IN = (b == spike_bit && (k == p/2 || k == 2)) ? ~v : v;
        @(negedge CLK);
      end
      // Mid-frame configuration changes must be ignored.
      if (b == 0) begin
        PRESCALE = (p == 8) ? 6'd32 : 6'd8;
        PAR_EN   = !par_en;
      end
    end
    PRESCALE = 6'(p);
    PAR_EN   = par_en;
  endtask

  task automatic settle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    logic [14:0] outs;
    logic [2:0]  st;
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; inj_par_err = 1'b0;
    repeat (3) @(negedge CLK);
    outs = {bus.P_DATA, bus.sampled_bit, bus.par_chk_en, bus.data_valid,
            bus.par_err_o, bus.stp_err, bus.strt_glitch};
    st = dut.state;
    n_checks++;
    if (outs !== 15'h0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h expected %h", outs, 15'h0); end
    n_checks++;
    if (st !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected %0d", st, 0); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_frame;
    int c0, dv0, err0;
    logic [2:0] st;
    dv0 = dv_cnt; err0 = pe_cnt + se_cnt + sg_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, c0);
    st = dut.state;
    n_checks++;
    if (st !== 3'd0) begin n_fail++; $display("[TB] FAIL basic_idle_at_80: got %0d expected %0d", st, 0); end
    settle(4);
    n_checks++;
    if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL basic_dv_count: got %0d expected %0d", dv_cnt - dv0, 1); end
    n_checks++;
    if (dv_cyc - c0 !== 80) begin n_fail++; $display("[TB] FAIL basic_dv_cycle: got %0d expected %0d", dv_cyc - c0, 80); end
    n_checks++;
    if (bus.P_DATA !== 8'hA5) begin n_fail++; $display("[TB] FAIL basic_pdata: got %h expected %h", bus.P_DATA, 8'hA5); end
    n_checks++;
    if (pe_cnt + se_cnt + sg_cnt - err0 !== 0) begin n_fail++; $display("[TB] FAIL basic_no_err: got %0d expected %0d", pe_cnt + se_cnt + sg_cnt - err0, 0); end
  endtask

  task automatic test_parity_ok;
    int c0, chk0, pe0;
    chk0 = chk_cnt; pe0 = pe_cnt; inj_par_err = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, c0);
    n_checks++;
    if (bus.data_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL parok_dv: got %b expected %b", bus.data_valid, 1'b1); end
    settle(4);
    n_checks++;
    if (chk_cnt - chk0 !== 1) begin n_fail++; $display("[TB] FAIL parok_chk_count: got %0d expected %0d", chk_cnt - chk0, 1); end
    n_checks++;
    if (chk_cyc - c0 !== 155) begin n_fail++; $display("[TB] FAIL parok_chk_cycle: got %0d expected %0d", chk_cyc - c0, 155); end
    n_checks++;
    if (bus.P_DATA !== 8'h3C) begin n_fail++; $display("[TB] FAIL parok_pdata: got %h expected %h", bus.P_DATA, 8'h3C); end
    n_checks++;
    if (pe_cnt - pe0 !== 0) begin n_fail++; $display("[TB] FAIL parok_no_pe: got %0d expected %0d", pe_cnt - pe0, 0); end
  endtask

  task automatic test_parity_err;
    int c0, dv0, pe0;
    dv0 = dv_cnt; pe0 = pe_cnt; inj_par_err = 1'b1;
    send_frame(8'h81, 32, 1'b1, 1'b0, 1'b1, -1, c0);
    settle(4);
    inj_par_err = 1'b0;
    n_checks++;
    if (pe_cnt - pe0 !== 1) begin n_fail++; $display("[TB] FAIL parerr_count: got %0d expected %0d", pe_cnt - pe0, 1); end
    n_checks++;
    if (pe_cyc - c0 !== 352) begin n_fail++; $display("[TB] FAIL parerr_cycle: got %0d expected %0d", pe_cyc - c0, 352); end
    n_checks++;
    if (dv_cnt - dv0 !== 0) begin n_fail++; $display("[TB] FAIL parerr_no_dv: got %0d expected %0d", dv_cnt - dv0, 0); end
  endtask

  task automatic test_stop_err_back_to_back;
    int c0, dv0, se0, pe0;
    dv0 = dv_cnt; se0 = se_cnt; pe0 = pe_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1, c0);
    n_checks++;
    if (bus.stp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_err_pulse: got %b expected %b", bus.stp_err, 1'b1); end
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, -1, c0);
    n_checks++;
    if (bus.data_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_dv: got %b expected %b", bus.data_valid, 1'b1); end
    settle(4);
    n_checks++;
    if (bus.P_DATA !== 8'h0F) begin n_fail++; $display("[TB] FAIL b2b_pdata: got %h expected %h", bus.P_DATA, 8'h0F); end
    n_checks++;
    if ({se_cnt - se0, dv_cnt - dv0, pe_cnt - pe0} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL b2b_counts: got se=%0d dv=%0d pe=%0d expected se=1 dv=1 pe=0", se_cnt - se0, dv_cnt - dv0, pe_cnt - pe0);
    end
  endtask

  task automatic test_start_glitch;
    int c0, sg0;
    logic [2:0] st;
    sg0 = sg_cnt;
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    c0 = cyc;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    settle(20);
    st = dut.state;
    n_checks++;
    if (sg_cnt - sg0 !== 1) begin n_fail++; $display("[TB] FAIL glitch_count: got %0d expected %0d", sg_cnt - sg0, 1); end
    n_checks++;
    if (sg_cyc - c0 !== 11) begin n_fail++; $display("[TB] FAIL glitch_cycle: got %0d expected %0d", sg_cyc - c0, 11); end
    n_checks++;
    if (st !== 3'd0) begin n_fail++; $display("[TB] FAIL glitch_idle: got %0d expected %0d", st, 0); end
    n_checks++;
    if (bus.P_DATA !== 8'h0F) begin n_fail++; $display("[TB] FAIL glitch_pdata: got %h expected %h", bus.P_DATA, 8'h0F); end
  endtask

  task automatic test_spike;
    int c0, dv0;
    dv0 = dv_cnt;
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b1, 4, c0);
    settle(4);
    n_checks++;
    if (bus.P_DATA !== 8'h96) begin n_fail++; $display("[TB] FAIL spike_pdata: got %h expected %h", bus.P_DATA, 8'h96); end
    n_checks++;
    if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL spike_dv: got %0d expected %0d", dv_cnt - dv0, 1); end
  endtask

  task automatic test_reset_mid_frame;
    int c0, dv0;
    logic [14:0] outs;
    logic [2:0]  st;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (36) @(negedge CLK);
    n_checks++;
    if (bus.P_DATA !== 8'h9F) begin n_fail++; $display("[TB] FAIL midframe_partial: got %h expected %h", bus.P_DATA, 8'h9F); end
    RST = 1'b1;
    @(negedge CLK);
    outs = {bus.P_DATA, bus.sampled_bit, bus.par_chk_en, bus.data_valid,
            bus.par_err_o, bus.stp_err, bus.strt_glitch};
    st = dut.state;
    n_checks++;
    if (outs !== 15'h0) begin n_fail++; $display("[TB] FAIL midreset_outputs: got %h expected %h", outs, 15'h0); end
    n_checks++;
    if (st !== 3'd0) begin n_fail++; $display("[TB] FAIL midreset_state: got %0d expected %0d", st, 0); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    dv0 = dv_cnt;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, c0);
    settle(4);
    n_checks++;
    if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL postreset_dv: got %0d expected %0d", dv_cnt - dv0, 1); end
    n_checks++;
    if (bus.P_DATA !== 8'h12) begin n_fail++; $display("[TB] FAIL postreset_pdata: got %h expected %h", bus.P_DATA, 8'h12); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_ok();
    test_parity_err();
    test_stop_err_back_to_back();
    test_start_glitch();
    test_spike();
    test_reset_mid_frame();
    n_checks++;
    if (ovl_cnt !== 0) begin n_fail++; $display("[TB] FAIL pulse_overlap: got %0d expected %0d", ovl_cnt, 0); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
